// File: rtl/dsp_multi_peak_meter.sv
// dsp_multi_peak_meter: per-channel audio peak meter with frame latch, hold+decay and sticky-max modes
module dsp_multi_peak_meter #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 16,
  parameter int HOLD_FRAMES = 8,
  parameter int DECAY_SHIFT = 3
) (
  input  logic                            iCLK,
  input  logic                            iRST_N,
  input  logic                            iSAMPLE_STB,
  input  logic [CHANNELS*WIDTH-1:0]       iSAMPLES,
  input  logic                            iFRAME_STB,
  input  logic [1:0]                      iMODE,
  input  logic                            iCLEAR,
  output logic [CHANNELS*(WIDTH-1)-1:0]   oPEAK,
  output logic [CHANNELS-1:0]             oOVF,
  output logic                            oVALID
);
  localparam int PW = WIDTH - 1;
  localparam int HW = HOLD_FRAMES > 0 ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_FRAMES);
  logic absV;
  always_ff @(posedge iCLK) begin
    if (!iRST_N || iCLEAR) begin
      absV   <= 1'b0;
      oVALID <= 1'b0;
    end else begin
      absV   <= iSAMPLE_STB;
      oVALID <= iFRAME_STB;
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : gCh
    logic signed [WIDTH-1:0] x;
    logic                    minCode;
    logic [PW-1:0]           absD, absQ, acc, peakQ, fm, dec, decayed;
    logic [HW-1:0]           hold;
    logic                    ovfQ;
    assign x = iSAMPLES[c*WIDTH +: WIDTH];
    assign oPEAK[c*PW +: PW] = peakQ;
    assign oOVF[c] = ovfQ;
    always_comb begin
      minCode = x == {1'b1, {PW{1'b0}}};
      absD    = minCode ? {PW{1'b1}} : (x[WIDTH-1] ? PW'(-x) : x[PW-1:0]);
      fm      = (absV && absQ > acc) ? absQ : acc;
      dec     = (peakQ >> DECAY_SHIFT) == '0 ? PW'(1) : peakQ >> DECAY_SHIFT;
      decayed = peakQ > dec ? peakQ - dec : '0;
    end
    // Hold is preloaded outside mode 1 so entering mode 1 starts a fresh hold
    always_ff @(posedge iCLK) begin
      if (!iRST_N || iCLEAR) begin
        absQ  <= '0;
        acc   <= '0;
        peakQ <= '0;
        hold  <= '0;
        ovfQ  <= 1'b0;
      end else begin
        if (iSAMPLE_STB) absQ <= absD;
        if (iSAMPLE_STB && minCode) ovfQ <= 1'b1;
        acc <= iFRAME_STB ? '0 : fm;
        if (iFRAME_STB) begin
          if (iMODE == 2'd1) begin
            if (fm >= peakQ) begin
              peakQ <= fm;
              hold  <= HOLD_INIT;
            end else if (hold != '0) hold <= hold - 1'b1;
            else peakQ <= fm > decayed ? fm : decayed;
          end else begin
            peakQ <= (iMODE == 2'd2 && peakQ > fm) ? peakQ : fm;
            hold  <= HOLD_INIT;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_dsp_multi_peak_meter.sv
// tb_dsp_multi_peak_meter: randomized + directed scoreboard bench against a frame-level peak model
module tb_dsp_multi_peak_meter;
  localparam int CH = 2, W = 16, HF = 8, DS = 3;
  logic iCLK = 1'b0;
  logic iRST_N = 1'b0, iSAMPLE_STB = 1'b0, iFRAME_STB = 1'b0, iCLEAR = 1'b0;
  logic [CH*W-1:0] iSAMPLES = '0;
  logic [1:0] iMODE = 2'd0;
  logic [CH*(W-1)-1:0] oPEAK;
  logic [CH-1:0] oOVF;
  logic oVALID;
  always #5 iCLK = ~iCLK;
  dsp_multi_peak_meter #(.CHANNELS(CH), .WIDTH(W), .HOLD_FRAMES(HF), .DECAY_SHIFT(DS)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iSAMPLE_STB(iSAMPLE_STB), .iSAMPLES(iSAMPLES),
    .iFRAME_STB(iFRAME_STB), .iMODE(iMODE), .iCLEAR(iCLEAR),
    .oPEAK(oPEAK), .oOVF(oOVF), .oVALID(oVALID));
  typedef struct { int p0; int p1; int ovf; } exp_t;
  exp_t expQ[$];
  int errors = 0, checks = 0;
  int mPeak[CH], mHold[CH], mFmax[CH], mPend[CH], mOvf;
  bit mPendV;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int sabs(input int v);
    int a;
    a = v < 0 ? -v : v;
    return a > 32767 ? 32767 : a;
  endfunction
  // Frame-level reference: a sample strobed in one cycle becomes visible to frames closed from the next cycle on
  task automatic step(input bit s, input int a0, input int a1, input bit f, input int m, input bit c, input bit r = 1'b1);
    int v[CH], fm, a, d, t;
    @(negedge iCLK);
    iRST_N = r; iSAMPLE_STB = s; iSAMPLES = {16'(a1), 16'(a0)};
    iFRAME_STB = f; iMODE = 2'(m); iCLEAR = c;
    v[0] = a0; v[1] = a1;
    if (!r || c) begin
      for (int k = 0; k < CH; k++) begin mPeak[k] = 0; mHold[k] = 0; mFmax[k] = 0; mPend[k] = 0; end
      mOvf = 0; mPendV = 0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        a = mPendV ? mPend[k] : 0;
        fm = mFmax[k] > a ? mFmax[k] : a;
        if (f) begin
          mFmax[k] = 0;
          if (m == 1) begin
            if (fm >= mPeak[k]) begin mPeak[k] = fm; mHold[k] = HF; end
            else if (mHold[k] != 0) mHold[k]--;
            else begin
              d = mPeak[k] >> DS; if (d < 1) d = 1;
              t = mPeak[k] - d; if (t < 0) t = 0;
              mPeak[k] = fm > t ? fm : t;
            end
          end else begin
            mPeak[k] = (m == 2 && mPeak[k] > fm) ? mPeak[k] : fm;
            mHold[k] = HF;
          end
        end else mFmax[k] = fm;
        if (s) begin
          mPend[k] = sabs(v[k]);
          if (v[k] == -32768) mOvf |= 1 << k;
        end
      end
      mPendV = s;
      if (f) expQ.push_back('{mPeak[0], mPeak[1], mOvf});
    end
  endtask
  task automatic idle(input int n = 1);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask
  task automatic frame(input int m);
    step(0, 0, 0, 1, m, 0);
  endtask
  always @(posedge iCLK) begin
    exp_t e;
    #1;
    if (!iRST_N) begin
      chk("reset_peak", int'(oPEAK), 0);
      chk("reset_ovf", int'(oOVF), 0);
      chk("reset_valid", int'(oVALID), 0);
    end else if (oVALID) begin
      if (expQ.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        e = expQ.pop_front();
        chk("peak0", int'(oPEAK[0 +: W-1]), e.p0);
        chk("peak1", int'(oPEAK[W-1 +: W-1]), e.p1);
        chk("ovf", int'(oOVF), e.ovf);
      end
    end
  end
  initial begin
    int r0, r1;
    for (int i = 0; i < 3; i++) step(1, 1000, -2000, 1, 0, 0, 0);
    idle(2);
    step(1, 100, -5, 0, 0, 0); step(1, -3000, 0, 0, 0, 0); step(1, 2000, 0, 0, 0, 0);
    frame(0); idle(); frame(0); idle();
    step(1, 0, -32768, 0, 0, 0); frame(0); idle(); frame(0); frame(0); idle();
    step(0, 0, 0, 0, 0, 1); idle(); frame(0); idle();
    step(1, 16384, 0, 0, 0, 0); frame(1);
    for (int i = 0; i < 12; i++) frame(1);
    step(0, 0, 0, 0, 0, 1);
    step(1, 5, 0, 0, 0, 0); frame(1);
    for (int i = 0; i < 16; i++) frame(1);
    step(0, 0, 0, 0, 0, 1);
    step(1, 7000, 0, 0, 0, 0); step(1, 9000, 0, 1, 0, 0); frame(0); idle();
    step(1, 4000, 4000, 0, 0, 0); step(0, 0, 0, 1, 0, 1); idle(2);
    step(1, 800, 0, 0, 0, 0); frame(2); step(1, 300, 0, 0, 0, 0); frame(2);
    step(1, 1200, 0, 0, 0, 0); frame(2); step(1, 500, 0, 0, 0, 0); frame(0); idle();
    for (int i = 0; i < 600; i++) begin
      r0 = $urandom_range(0, 15) == 0 ? -32768 : int'($urandom_range(0, 65535)) - 32768;
      r1 = $urandom_range(0, 15) == 0 ? -32768 : int'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 3) == 0) begin r0 = r0 >>> 8; r1 = r1 >>> 8; end
      step($urandom_range(0, 2) == 0, r0, r1, $urandom_range(0, 4) == 0,
           int'($urandom_range(0, 3)), $urandom_range(0, 79) == 0);
    end
    idle(4);
    chk("drain", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
